// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I and D requesters.
// Latency: strobes one cycle after a request is seen in IDLE; resp pulse combinational with mem_resp.
// Backpressure: requests are levels held until resp; at least one IDLE cycle separates transactions.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_addr,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_addr,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [1:0] state;
    logic       last_grant;
    logic       d_req;
    logic       pick_d;

    assign d_req  = d_read | d_write;
    // D wins when it is alone, or when both contend and I was granted last.
    assign pick_d = d_req && (!i_read || (last_grant == GNT_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_read || d_req) begin
                        if (pick_d) begin
                            state      <= SERVE_D;
                            last_grant <= GNT_D;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                            // A simultaneous read+write is issued as a write only.
                            mem_write  <= d_write;
                            mem_read   <= d_read & ~d_write;
                        end else begin
                            state      <= SERVE_I;
                            last_grant <= GNT_I;
                            mem_addr   <= i_addr;
                            mem_wdata  <= '0;
                            mem_write  <= 1'b0;
                            mem_read   <= 1'b1;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign i_resp  = (state == SERVE_I) && mem_resp;
    assign d_resp  = (state == SERVE_D) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded random bench for mem_arbiter with a transaction-level round-robin model.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic         rd;
        logic         wr;
    } req_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_read = 1'b0;
    logic [31:0]  i_addr = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int total = 0;
    int bad = 0;

    req_t i_q[$];
    req_t d_q[$];

    logic mon_en = 1'b0;
    logic rsp_en = 1'b0;
    logic stray_en = 1'b0;
    int   lat_lo = 0;
    int   lat_hi = 3;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Requester tasks: entered and left at posedge+1.
    task automatic do_i(input logic [31:0] addr);
        req_t e;
        int   n;
        e.addr = addr; e.wdata = '0; e.rd = 1'b1; e.wr = 1'b0;
        i_q.push_back(e);
        i_addr = addr;
        i_read = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!i_resp && n < 100);
        if (!i_resp) chk("i_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic do_d(input logic [31:0] addr, input logic rd, input logic wr);
        req_t e;
        int   n;
        e.addr = addr; e.wdata = rand_line(); e.rd = rd; e.wr = wr;
        d_q.push_back(e);
        d_addr  = addr;
        d_wdata = e.wdata;
        d_read  = rd;
        d_write = wr;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!d_resp && n < 100);
        if (!d_resp) chk("d_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rsp_en = 1'b0;
        mem_resp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        i_q.delete();
        d_q.delete();
        @(posedge clk); #1;
        mon_en = 1'b1;
        rsp_en = 1'b1;
    endtask

    // Memory model: responds after a random latency, optionally injects stray responses while idle.
    initial begin
        logic busy;
        int   cnt;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rsp_en && !rst) begin
                mem_resp  = 1'b0;
                mem_rdata = rand_line();
                if (!busy && (mem_read || mem_write)) begin
                    busy = 1'b1;
                    cnt  = $urandom_range(lat_hi, lat_lo);
                end
                if (busy) begin
                    if (cnt == 0) begin
                        mem_resp = 1'b1;
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (stray_en && ($urandom_range(5, 0) == 0)) begin
                    mem_resp = 1'b1;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: decides the expected grant from which sides were pending and who won last time.
    initial begin
        logic in_txn, side, last_g, after_resp, prev_i, prev_d, prev_idle, strobe;
        req_t exp;
        in_txn = 0; side = 0; last_g = 0; after_resp = 0;
        prev_i = 0; prev_d = 0; prev_idle = 1; strobe = 0;
        exp = '0;
        forever begin
            @(negedge clk); #1;
            if (!mon_en || rst) begin
                in_txn = 0; side = 0; last_g = 0; after_resp = 0;
                prev_i = 0; prev_d = 0; prev_idle = 1;
            end else begin
                strobe = mem_read | mem_write;
                chk("i_rdata_pass", i_rdata, mem_rdata);
                chk("d_rdata_pass", d_rdata, mem_rdata);
                if (after_resp) begin
                    chk("idle_gap", 256'(strobe), 256'd0);
                    after_resp = 0;
                end else if (prev_idle) begin
                    chk("grant_latency", 256'(strobe), 256'(prev_i | prev_d));
                    if (strobe && (prev_i || prev_d)) begin
                        side   = (prev_i && prev_d) ? ~last_g : prev_d;
                        last_g = side;
                        exp    = '0;
                        if (side) begin
                            if (d_q.size() == 0) chk("d_queue_empty", 256'd0, 256'd1);
                            else exp = d_q.pop_front();
                        end else begin
                            if (i_q.size() == 0) chk("i_queue_empty", 256'd0, 256'd1);
                            else exp = i_q.pop_front();
                        end
                        exp.rd = exp.rd & ~exp.wr;
                        chk(side ? "grant_d_addr" : "grant_i_addr", 256'(mem_addr), 256'(exp.addr));
                        chk(side ? "grant_d_wdata" : "grant_i_wdata", mem_wdata, exp.wdata);
                        chk(side ? "grant_d_cmd" : "grant_i_cmd", 256'({mem_read, mem_write}),
                            256'({exp.rd, exp.wr}));
                        in_txn = 1;
                    end
                end else if (in_txn) begin
                    chk("hold_addr", 256'(mem_addr), 256'(exp.addr));
                    chk("hold_wdata", mem_wdata, exp.wdata);
                    chk("hold_cmd", 256'({mem_read, mem_write}), 256'({exp.rd, exp.wr}));
                end
                if (in_txn && mem_resp) begin
                    chk("resp_pulse", 256'({i_resp, d_resp}), 256'({~side, side}));
                    in_txn = 0;
                    after_resp = 1;
                end else begin
                    chk("no_resp", 256'({i_resp, d_resp}), 256'd0);
                end
                prev_i    = i_read;
                prev_d    = d_read | d_write;
                prev_idle = !strobe;
            end
        end
    end

    initial begin
        // Reset state while rst is held.
        #3;
        chk("rst_mem_read", 256'(mem_read), 256'd0);
        chk("rst_mem_write", 256'(mem_write), 256'd0);
        chk("rst_mem_addr", 256'(mem_addr), 256'd0);
        chk("rst_mem_wdata", mem_wdata, 256'd0);
        chk("rst_resp", 256'({i_resp, d_resp}), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        rsp_en = 1'b1;

        // I-only read with a fixed three-cycle memory latency.
        lat_lo = 3; lat_hi = 3;
        do_i(32'h0000_1000);
        gap(2);

        // Contention right after reset: D first, then I.
        do_reset();
        lat_lo = 0; lat_hi = 2;
        fork
            do_d(32'h0000_2000, 1'b0, 1'b1);
            do_i(32'h0000_2100);
        join
        gap(2);

        // Continuous requests on both sides: D, I, D, I.
        fork
            begin do_d(32'h0000_2200, 1'b1, 1'b0); do_d(32'h0000_2400, 1'b0, 1'b1); end
            begin do_i(32'h0000_2300); do_i(32'h0000_2500); end
        join
        gap(2);

        // D address changes while I is being served; the later D grant takes the new address.
        lat_lo = 4; lat_hi = 4;
        fork
            do_i(32'h0000_6000);
            begin
                gap(1);
                fork
                    do_d(32'h0000_3000, 1'b1, 1'b0);
                    begin
                        req_t t;
                        gap(1);
                        d_addr = 32'h0000_4000;
                        t = d_q[0];
                        t.addr = 32'h0000_4000;
                        d_q[0] = t;
                    end
                join
            end
        join
        gap(2);

        // Asynchronous reset in the middle of a D write, then a stray mem_resp.
        mon_en = 1'b0;
        rsp_en = 1'b0;
        d_addr = 32'h0000_5000;
        d_wdata = rand_line();
        d_write = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_write", 256'(mem_write), 256'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_write", 256'(mem_write), 256'd0);
        chk("async_rst_read", 256'(mem_read), 256'd0);
        chk("async_rst_addr", 256'(mem_addr), 256'd0);
        d_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_resp = 1'b1;
        @(negedge clk); #1;
        chk("stray_after_rst_resp", 256'({i_resp, d_resp}), 256'd0);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk); #1;
        chk("stray_after_rst_idle", 256'({mem_read, mem_write}), 256'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        rsp_en = 1'b1;

        // Read+write together is a write; stray responses in IDLE are dropped.
        lat_lo = 0; lat_hi = 3;
        stray_en = 1'b1;
        do_d(32'h0000_7000, 1'b1, 1'b1);
        gap(4);

        // Random traffic from both sides.
        fork
            for (int k = 0; k < 60; k++) begin
                gap($urandom_range(3, 0));
                do_i($urandom);
            end
            for (int k = 0; k < 60; k++) begin
                logic [1:0] kind;
                gap($urandom_range(3, 0));
                kind = 2'($urandom_range(3, 0));
                do_d($urandom, kind != 2'd2, kind[1]);
            end
        join
        gap(4);
        chk("i_queue_drained", 256'(i_q.size()), 256'd0);
        chk("d_queue_drained", 256'(d_q.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports:
  clk  in  1  single clock; all state updates on the rising edge
  rst  in  1  asynchronous, active-high reset
  i_read  in  1  instruction-side line read request, level, held until i_resp
  i_addr  in  32  instruction-side line address
  i_rdata  out  256  instruction-side read data
  i_resp  out  1  instruction-side completion pulse
  d_read  in  1  data-side line read request, level, held until d_resp
  d_write  in  1  data-side line write request, level, held until d_resp
  d_addr  in  32  data-side line address
  d_wdata  in  256  data-side write line
  d_rdata  out  256  data-side read data
  d_resp  out  1  data-side completion pulse
  mem_read  out  1  downstream read strobe
  mem_write  out  1  downstream write strobe
  mem_addr  out  32  downstream address
  mem_wdata  out  256  downstream write line
  mem_rdata  in  256  downstream read data, valid when mem_resp=1
  mem_resp  in  1  downstream completion, one cycle

Function
REQ-002 The block SHALL implement a three-state FSM: IDLE, SERVE_I, SERVE_D.
REQ-003 In IDLE with only the I request pending, the block SHALL go to SERVE_I; with only a D request (d_read or d_write) pending, it SHALL go to SERVE_D.
REQ-004 In IDLE with both requests pending, the block SHALL grant the side not recorded in the 1-bit last_grant register (round-robin).
REQ-005 On every grant, last_grant SHALL be updated to the granted side.
REQ-006 On the grant edge, the block SHALL register mem_addr, mem_wdata (D only; 0 for I), mem_read and mem_write from the granted requester.
REQ-007 Downstream strobes SHALL assert in the cycle after the request is first seen in IDLE. Minimum latency: 1 cycle from request to strobe.
REQ-008 mem_addr, mem_wdata, mem_read and mem_write SHALL remain stable while in SERVE_I or SERVE_D until mem_resp is sampled.
REQ-009 If the D side asserts d_read and d_write together, the block SHALL issue a write only (mem_write=1, mem_read=0).
REQ-010 While in SERVE_x with mem_resp=1, the block SHALL combinationally assert x_resp for that same cycle and pass mem_rdata through to x_rdata.
REQ-011 On the edge ending a mem_resp cycle, the block SHALL clear mem_read/mem_write and return to IDLE. There is no back-to-back issue: at least one IDLE cycle separates transactions.
REQ-012 i_rdata and d_rdata SHALL be driven from mem_rdata at all times. Only the x_resp pulses qualify this data.
REQ-013 i_resp and d_resp SHALL never be asserted in the same cycle, and SHALL never be asserted outside the matching SERVE state.
REQ-014 mem_resp received in IDLE SHALL be ignored, with no state change and no resp pulse.
REQ-015 Request changes on the non-granted side SHALL have no effect until the FSM returns to IDLE.
REQ-016 Requesters SHALL deassert in the cycle after their resp. A request still high in IDLE is treated as a new request.

Reset
REQ-017 While rst=1, the block SHALL immediately set state=IDLE, last_grant=I (so D wins the first contention), mem_read=0, mem_write=0, mem_addr=0 and mem_wdata=0. This applies asynchronously, including mid-transaction.
REQ-018 After reset, i_resp and d_resp SHALL be 0. No pending transaction SHALL be resumed after reset, and any mem_resp arriving afterwards in IDLE is dropped per REQ-014.

Verification
REQ-019 I-only read: i_read=1, i_addr=0x0000_1000, mem_resp one cycle after 3 cycles with mem_rdata=0xA5..A5 -> mem_read=1 with addr 0x1000 one cycle after request; i_resp=1 and i_rdata=0xA5..A5 in the mem_resp cycle; d_resp=0 throughout.
REQ-020 Simultaneous requests after reset: i_read and d_write (addr 0x2000) in the same cycle -> D served first (mem_write=1, addr 0x2000); after d_resp and one IDLE cycle, I served (mem_read=1).
REQ-021 Round-robin: both sides hold requests continuously for four transactions -> grant order D, I, D, I.
REQ-022 Stability: change d_addr from 0x3000 to 0x4000 during SERVE_I -> mem_addr holds the I address until mem_resp; the later D grant uses 0x4000.
REQ-023 Reset mid-transaction: assert rst during SERVE_D before mem_resp -> mem_write=0 and state IDLE immediately (asynchronous); a subsequent stray mem_resp produces no d_resp.
REQ-024 Illegal D command: d_read=1 and d_write=1 -> mem_write=1, mem_read=0; a stray mem_resp in IDLE -> no resp pulses.
